// File: rtl/mod_seq_ctrl_if.sv
// Operand/result bundle for the sequential divide/modulo controller.
// The master drives the operands and start; the slave returns status and results.
interface mod_seq_ctrl_if #(
   parameter int num_width = 8
);
   logic                 start;
   logic [num_width-1:0] dividend;
   logic [num_width-1:0] divisor;
   logic                 busy;
   logic                 done;
   logic [num_width-1:0] quotient;
   logic [num_width-1:0] remainder;
   logic                 div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/mod_seq_ctrl.sv
// Restoring divider: one conditional-subtract step per clock, MSB first,
// producing quotient and remainder with a start/done handshake.
module mod_seq_ctrl #(
   parameter int num_width = 8
) (
   input  logic          clk,
   input  logic          rst,
   mod_seq_ctrl_if.slave bus
);

   localparam int CNT_W = (num_width > 1) ? $clog2(num_width) : 1;

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   state_t               r_state;
   logic [num_width-1:0] r_dividend;
   logic [num_width-1:0] r_divisor;
   logic [num_width-1:0] r_p;
   logic [num_width-1:0] r_quot;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_dbz;
   logic [num_width-1:0] r_quotient;
   logic [num_width-1:0] r_remainder;

   logic [num_width:0]   w_shift;
   logic [num_width:0]   w_divExt;
   logic                 w_ge;
   logic [num_width-1:0] w_pNext;
   logic [num_width-1:0] w_qNext;

   // The stored partial remainder is always below the divisor, so it fits in
   // num_width bits; only the shifted value needs the extra top bit.
   assign w_shift  = {r_p, r_dividend[r_cnt]};
   assign w_divExt = {1'b0, r_divisor};
   assign w_ge     = (w_shift >= w_divExt);
   assign w_pNext  = w_ge ? num_width'(w_shift - w_divExt) : w_shift[num_width-1:0];
   assign w_qNext  = {r_quot[num_width-2:0], w_ge};

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_p         <= '0;
         r_quot      <= '0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_dbz       <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_dividend <= bus.dividend;
                  r_divisor  <= bus.divisor;
                  r_p        <= '0;
                  r_quot     <= '0;
                  // A zero divisor is resolved immediately without iterating.
                  if (bus.divisor == '0) begin
                     r_done      <= 1'b1;
                     r_dbz       <= 1'b1;
                     r_quotient  <= '1;
                     r_remainder <= bus.dividend;
                  end else begin
                     r_dbz       <= 1'b0;
                     r_quotient  <= '0;
                     r_remainder <= '0;
                     r_cnt       <= CNT_W'(num_width - 1);
                     r_busy      <= 1'b1;
                     r_state     <= CALC;
                  end
               end
            end
            CALC: begin
               r_p    <= w_pNext;
               r_quot <= w_qNext;
               r_cnt  <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_remainder <= w_pNext;
                  r_quotient  <= w_qNext;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Self-checking bench for mod_seq_ctrl: directed table, multi-cycle corner
// sequences and a random sweep, all scored against an arithmetic reference.
module tb_mod_seq_ctrl;

   localparam int W       = 8;
   localparam int LAT     = W + 1;
   localparam int TIMEOUT = 40;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           lat;
   } exp_t;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   exp_t sb[$];
   vec_t vecs[7];

   mod_seq_ctrl_if #(.num_width(W)) bus();

   mod_seq_ctrl #(.num_width(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference result: plain integer arithmetic, zero divisor handled separately.
   task automatic pushModel(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = LAT;
      end
      sb.push_back(e);
   endtask

   task automatic pushTable(input vec_t v);
      exp_t e;
      e.q = v.q; e.r = v.r; e.dbz = v.dbz;
      e.lat = v.dbz ? 1 : LAT;
      sb.push_back(e);
   endtask

   // Wait for done, counting edges since start was raised (first edge already taken).
   task automatic waitDone(inout int lat, inout bit sawBusy);
      while (!bus.done && lat < TIMEOUT) begin
         @(posedge clk); #1;
         lat++;
         if (bus.busy) sawBusy = 1'b1;
      end
      if (!bus.done) checkVal("doneTimeout", 0, 1);
   endtask

   task automatic checkOutput(input int lat, input bit sawBusy);
      exp_t e;
      if (sb.size() == 0) begin
         checkVal("scoreboardEmpty", 0, 1);
         return;
      end
      e = sb.pop_front();
      checkVal("quotient", int'(bus.quotient), int'(e.q));
      checkVal("remainder", int'(bus.remainder), int'(e.r));
      checkVal("divByZero", int'(bus.div_by_zero), int'(e.dbz));
      checkVal("latency", lat, e.lat);
      checkVal("busyAtDone", int'(bus.busy), 0);
      checkVal("busySeen", int'(sawBusy), e.dbz ? 0 : 1);
   endtask

   // Raise start now; the caller has already pushed the expected result.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      bit sawBusy;
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat       = 1;
      sawBusy   = bus.busy;
      if (b != 0) begin
         checkVal("acceptBusy", int'(bus.busy), 1);
         checkVal("acceptQuot", int'(bus.quotient), 0);
         checkVal("acceptRem", int'(bus.remainder), 0);
         checkVal("acceptDbz", int'(bus.div_by_zero), 0);
      end
      waitDone(lat, sawBusy);
      checkOutput(lat, sawBusy);
   endtask

   initial begin
      int lat;
      bit sawBusy;
      int doneCount;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      compared   = 0;
      mismatched = 0;
      vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   dbz: 1'b0};
      vecs[1] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dbz: 1'b0};
      vecs[2] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dbz: 1'b0};
      vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0};
      vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,   dbz: 1'b0};
      vecs[5] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100, dbz: 1'b1};
      vecs[6] = '{a: 8'd13,  b: 8'd4,   q: 8'd3,   r: 8'd1,   dbz: 1'b0};

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("resetBusy", int'(bus.busy), 0);
      checkVal("resetDone", int'(bus.done), 0);
      checkVal("resetQuot", int'(bus.quotient), 0);
      checkVal("resetRem", int'(bus.remainder), 0);
      checkVal("resetDbz", int'(bus.div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table, with an idle gap and a one-cycle done check after each.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         pushTable(vecs[i]);
         applyStimulus(vecs[i].a, vecs[i].b);
         @(posedge clk); #1;
         checkVal("donePulse", int'(bus.done), 0);
         checkVal("holdQuot", int'(bus.quotient), int'(vecs[i].q));
         checkVal("holdRem", int'(bus.remainder), int'(vecs[i].r));
      end

      // Start pulse mid-calculation and operand changes must be ignored.
      @(negedge clk);
      pushModel(8'd200, 8'd7);
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 8'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat       = 1;
      sawBusy   = bus.busy;
      repeat (2) begin
         @(posedge clk); #1;
         lat++;
      end
      bus.start    = 1'b1;
      bus.dividend = 8'd50;
      bus.divisor  = 8'd5;
      @(posedge clk); #1;
      lat++;
      bus.start    = 1'b0;
      bus.dividend = 8'hA5;
      bus.divisor  = 8'h03;
      waitDone(lat, sawBusy);
      checkOutput(lat, sawBusy);

      // Back-to-back: start raised in the done cycle is accepted.
      pushModel(8'd50, 8'd5);
      applyStimulus(8'd50, 8'd5);

      // Asynchronous reset mid-calculation clears everything without a done.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 8'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      checkVal("rstBusy", int'(bus.busy), 0);
      checkVal("rstDone", int'(bus.done), 0);
      checkVal("rstQuot", int'(bus.quotient), 0);
      checkVal("rstRem", int'(bus.remainder), 0);
      checkVal("rstDbz", int'(bus.div_by_zero), 0);
      @(posedge clk); #1;
      rst       = 1'b0;
      doneCount = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done) doneCount++;
      end
      checkVal("rstNoDone", doneCount, 0);
      pushModel(8'd13, 8'd4);
      applyStimulus(8'd13, 8'd4);

      // Divide-by-zero flag clears on the next accepted start.
      pushModel(8'd77, 8'd0);
      applyStimulus(8'd77, 8'd0);
      pushModel(8'd77, 8'd6);
      applyStimulus(8'd77, 8'd6);

      // Random sweep, mostly back-to-back, with occasional zero divisors.
      for (int n = 0; n < 3000; n++) begin
         ra = W'($urandom_range(0, 255));
         rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         pushModel(ra, rb);
         applyStimulus(ra, rb);
      end

      checkVal("scoreboardDrained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
